// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: shared definitions for the USB endpoint controller.
//   - handshake_e : handshake encodings returned to the protocol core
//   - MaxPktDefault : default packet buffer size in bytes
//   - ptr_width() : address width needed for a buffer of a given depth
package usb_ep_pkg;

  typedef enum logic [1:0] {
    hs_ack   = 2'b00,
    hs_none  = 2'b01,
    hs_nak   = 2'b10,
    hs_stall = 2'b11
  } handshake_e;

  localparam int unsigned MaxPktDefault = 64;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/usb_ep_ctrl_if.sv
// usb_ep_ctrl_if: transaction interface between the USB protocol core and the
// endpoint controller.
//   master (core side)  : drives transaction_active, endpoint, direction_in, setup,
//                         data_out, data_strobe, success; reads the rest
//   slave  (endpoint)   : drives data_toggle, handshake, data_in, data_in_valid
interface usb_ep_ctrl_if;
  import usb_ep_pkg::*;

  logic       transaction_active;
  logic [3:0] endpoint;
  logic       direction_in;
  logic       setup;
  logic [7:0] data_out;
  logic       data_strobe;
  logic       success;
  logic       data_toggle;
  handshake_e handshake;
  logic [7:0] data_in;
  logic       data_in_valid;

  modport master (
    output transaction_active, endpoint, direction_in, setup, data_out, data_strobe, success,
    input  data_toggle, handshake, data_in, data_in_valid
  );

  modport slave (
    input  transaction_active, endpoint, direction_in, setup, data_out, data_strobe, success,
    output data_toggle, handshake, data_in, data_in_valid
  );

endinterface

// File: rtl/usb_ep_pktbuf.sv
// usb_ep_pktbuf: simple dual-port byte RAM used as a packet buffer.
//   clk_48 : clock
//   we     : write enable; wdata stored at waddr
//   raddr  : read address
//   rdata  : mem[raddr], registered (1-cycle latency)
module usb_ep_pktbuf
  import usb_ep_pkg::*;
#(
  parameter int unsigned Depth = MaxPktDefault,
  parameter int unsigned AddrW = ptr_width(MaxPktDefault)
) (
  input  logic             clk_48,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_48) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/usb_ep_ctrl.sv
// usb_ep_ctrl: endpoint controller sitting behind the USB protocol core.
// Answers each core transaction with a handshake and data toggle, captures
// OUT/SETUP payloads into an RX buffer and sources IN payloads from a TX buffer.
//   clk_48, rst_n (sync, active low), usb_rst (sync bus reset, active high)
//   core          : transaction interface (slave modport)
//   rx_*          : held RX packet status, registered read port, release pulse
//   tx_*          : TX buffer write port, commit pulse, pending/done status
//   stall_set/clr : per-endpoint stall control (set wins)
// Optional: define USB_EP_STATS_EN to add saturating nak_count/stall_count outputs.
module usb_ep_ctrl
  import usb_ep_pkg::*;
#(
  parameter int unsigned NUM_EP  = 2,
  parameter int unsigned MAX_PKT = MaxPktDefault
) (
  input  logic              clk_48,
  input  logic              rst_n,
  input  logic              usb_rst,
  usb_ep_ctrl_if.slave      core,
  output logic              rx_valid,
  output logic [3:0]        rx_ep,
  output logic              rx_setup,
  output logic [6:0]        rx_len,
  input  logic [5:0]        rx_raddr,
  output logic [7:0]        rx_rdata,
  input  logic              rx_release,
  input  logic              tx_we,
  input  logic [5:0]        tx_waddr,
  input  logic [7:0]        tx_wdata,
  input  logic              tx_commit,
  input  logic [3:0]        tx_ep,
  input  logic [6:0]        tx_len,
  output logic              tx_pending,
  output logic              tx_done,
  input  logic [NUM_EP-1:0] stall_set,
  input  logic [NUM_EP-1:0] stall_clr
`ifdef USB_EP_STATS_EN
  ,
  output logic [15:0]       nak_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned AddrW = ptr_width(MAX_PKT);
  localparam int unsigned EpW   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  logic srst;
  assign srst = !rst_n || usb_rst;

  // State
  logic              active_q;
  logic [6:0]        wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [6:0]        rd_ptr_q, rd_ptr_d;
  logic              rx_valid_q, rx_valid_d;
  logic [3:0]        rx_ep_q, rx_ep_d;
  logic              rx_setup_q, rx_setup_d;
  logic [6:0]        rx_len_q, rx_len_d;
  logic              tx_pending_q, tx_pending_d;
  logic [3:0]        tx_ep_q, tx_ep_d;
  logic [6:0]        tx_len_q, tx_len_d;
  logic              tx_done_q, tx_done_d;
  logic [NUM_EP-1:0] out_tgl_q, out_tgl_d;
  logic [NUM_EP-1:0] in_tgl_q, in_tgl_d;
  logic [NUM_EP-1:0] stall_q, stall_d;

  // Transaction decode
  logic [EpW-1:0] ep_idx;
  logic           ep_ok;
  logic           stall_ep;
  logic           is_setup;
  logic           out_accept;
  logic           out_ack;
  logic           in_ack;
  logic           fall;
  logic           rx_we;
  logic           ovf_hit;
  logic           out_done;
  logic           in_done;
  logic           rx_latch;
  handshake_e     hs;
  logic [7:0]     tx_rdata;

  assign ep_idx   = core.endpoint[EpW-1:0];
  assign ep_ok    = {1'b0, core.endpoint} < 5'(NUM_EP);
  assign stall_ep = ep_ok && stall_q[ep_idx];
  assign is_setup = core.setup && !core.direction_in;
  assign fall     = active_q && !core.transaction_active;

  // SETUP bypasses the stall bit so the host can always recover the endpoint.
  assign out_accept = core.transaction_active && !core.direction_in && ep_ok &&
                      (is_setup || !stall_ep) && !rx_valid_q;
  assign out_ack    = out_accept && !overflow_q;
  assign in_ack     = core.transaction_active && core.direction_in && ep_ok && !stall_ep &&
                      tx_pending_q && (tx_ep_q == core.endpoint);

  // Bytes past MAX_PKT flag overflow, which turns the handshake into NAK and
  // makes the core withhold success.
  assign rx_we    = out_ack && core.data_strobe && (wr_ptr_q < 7'(MAX_PKT));
  assign ovf_hit  = out_ack && core.data_strobe && (wr_ptr_q == 7'(MAX_PKT));
  assign out_done = out_ack && core.success;
  assign in_done  = in_ack && core.success;
  // A release in the same cycle wins; the packet is not latched.
  assign rx_latch = out_done && !rx_release;

  always_comb begin
    hs = hs_nak;
    if (!core.transaction_active) begin
      hs = hs_nak;
    end else if (!ep_ok || (stall_ep && !is_setup)) begin
      hs = hs_stall;
    end else if (!core.direction_in) begin
      hs = out_ack ? hs_ack : hs_nak;
    end else begin
      hs = in_ack ? hs_ack : hs_nak;
    end
  end

  always_comb begin
    core.data_toggle = 1'b0;
    if (core.transaction_active && ep_ok) begin
      if (core.direction_in) begin
        core.data_toggle = in_tgl_q[ep_idx];
      end else if (!core.setup) begin
        core.data_toggle = out_tgl_q[ep_idx];
      end
    end
  end

  assign core.handshake     = hs;
  assign core.data_in       = tx_rdata;
  assign core.data_in_valid = in_ack && (rd_ptr_q < tx_len_q);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    overflow_d   = overflow_q;
    rd_ptr_d     = rd_ptr_q;
    rx_valid_d   = rx_valid_q;
    rx_ep_d      = rx_ep_q;
    rx_setup_d   = rx_setup_q;
    rx_len_d     = rx_len_q;
    tx_pending_d = tx_pending_q;
    tx_ep_d      = tx_ep_q;
    tx_len_d     = tx_len_q;
    tx_done_d    = 1'b0;
    out_tgl_d    = out_tgl_q;
    in_tgl_d     = in_tgl_q;
    stall_d      = stall_q & ~stall_clr;

    // RX write pointer
    if (rx_we) begin
      wr_ptr_d = wr_ptr_q + 7'd1;
    end
    if (ovf_hit) begin
      overflow_d = 1'b1;
    end
    if (fall || (core.transaction_active && core.success && !core.direction_in)) begin
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
    end

    // RX packet status
    if (rx_release) begin
      rx_valid_d = 1'b0;
    end else if (rx_latch) begin
      rx_valid_d = 1'b1;
      rx_len_d   = wr_ptr_q;
      rx_ep_d    = core.endpoint;
      rx_setup_d = is_setup;
    end

    // OUT/SETUP completion updates toggles even when the latch loses to a release,
    // since the host has already seen the ACK.
    if (out_done) begin
      if (is_setup) begin
        out_tgl_d[ep_idx] = 1'b1;
        in_tgl_d[ep_idx]  = 1'b1;
        stall_d[ep_idx]   = 1'b0;
      end else begin
        out_tgl_d[ep_idx] = ~out_tgl_q[ep_idx];
      end
    end

    // IN read pointer; rewinds on any transaction end so a retry resends from byte 0.
    if (in_ack && core.data_strobe && (rd_ptr_q < tx_len_q)) begin
      rd_ptr_d = rd_ptr_q + 7'd1;
    end
    if (fall || in_done) begin
      rd_ptr_d = '0;
    end

    // TX arm / completion
    if (in_done) begin
      tx_pending_d     = 1'b0;
      tx_done_d        = 1'b1;
      in_tgl_d[ep_idx] = ~in_tgl_q[ep_idx];
    end else if (tx_commit && !tx_pending_q) begin
      tx_pending_d = 1'b1;
      tx_ep_d      = tx_ep;
      tx_len_d     = tx_len;
    end

    stall_d = stall_d | stall_set;
  end

  always_ff @(posedge clk_48) begin
    if (srst) begin
      active_q     <= 1'b0;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      rd_ptr_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_ep_q      <= '0;
      rx_setup_q   <= 1'b0;
      rx_len_q     <= '0;
      tx_pending_q <= 1'b0;
      tx_ep_q      <= '0;
      tx_len_q     <= '0;
      tx_done_q    <= 1'b0;
      out_tgl_q    <= '0;
      in_tgl_q     <= '0;
      stall_q      <= '0;
    end else begin
      active_q     <= core.transaction_active;
      wr_ptr_q     <= wr_ptr_d;
      overflow_q   <= overflow_d;
      rd_ptr_q     <= rd_ptr_d;
      rx_valid_q   <= rx_valid_d;
      rx_ep_q      <= rx_ep_d;
      rx_setup_q   <= rx_setup_d;
      rx_len_q     <= rx_len_d;
      tx_pending_q <= tx_pending_d;
      tx_ep_q      <= tx_ep_d;
      tx_len_q     <= tx_len_d;
      tx_done_q    <= tx_done_d;
      out_tgl_q    <= out_tgl_d;
      in_tgl_q     <= in_tgl_d;
      stall_q      <= stall_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_ep      = rx_ep_q;
  assign rx_setup   = rx_setup_q;
  assign rx_len     = rx_len_q;
  assign tx_pending = tx_pending_q;
  assign tx_done    = tx_done_q;

  usb_ep_pktbuf #(
    .Depth (MAX_PKT),
    .AddrW (AddrW)
  ) u_rx_buf (
    .clk_48 (clk_48),
    .we     (rx_we),
    .waddr  (wr_ptr_q[AddrW-1:0]),
    .wdata  (core.data_out),
    .raddr  (rx_raddr[AddrW-1:0]),
    .rdata  (rx_rdata)
  );

  // The buffer is frozen while a packet is armed so a retry resends identical data.
  usb_ep_pktbuf #(
    .Depth (MAX_PKT),
    .AddrW (AddrW)
  ) u_tx_buf (
    .clk_48 (clk_48),
    .we     (tx_we && !tx_pending_q),
    .waddr  (tx_waddr[AddrW-1:0]),
    .wdata  (tx_wdata),
    .raddr  (rd_ptr_q[AddrW-1:0]),
    .rdata  (tx_rdata)
  );

`ifdef USB_EP_STATS_EN
  logic [15:0] nak_count_q, stall_count_q;
  handshake_e  last_hs_q;
  logic        done_seen_q;

  // The handshake seen just before success is the one the host got; freeze it
  // so post-success status changes (rx_valid, tx_pending) do not count as NAKs.
  always_ff @(posedge clk_48) begin
    if (srst) begin
      nak_count_q   <= '0;
      stall_count_q <= '0;
      last_hs_q     <= hs_none;
      done_seen_q   <= 1'b0;
    end else begin
      if (core.transaction_active && !done_seen_q) begin
        last_hs_q <= hs;
      end
      if (core.transaction_active && core.success) begin
        done_seen_q <= 1'b1;
      end
      if (fall) begin
        done_seen_q <= 1'b0;
        if (last_hs_q == hs_nak && nak_count_q != 16'hffff) begin
          nak_count_q <= nak_count_q + 16'd1;
        end
        if (last_hs_q == hs_stall && stall_count_q != 16'hffff) begin
          stall_count_q <= stall_count_q + 16'd1;
        end
      end
    end
  end

  assign nak_count   = nak_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
